fifo_uart_tx: RTL and testbench



---
 rtl/fifo_uart_tx.sv | 151 +++++++++++++++
 tb/tb_fifo_uart_tx.sv | 263 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/fifo_uart_tx.sv
// Drains a byte FIFO one pop at a time and serializes each byte as an 8N1 UART frame, LSB first.
// Define FIFO_UART_TX_PARITY_EN to insert an even-parity bit between the data bits and the stop bit.
module fifo_uart_tx #(
    parameter int CLKS_PER_BIT = 104,
    parameter int CNT_W        = 16
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       enable,
    input  logic       emptyB,
    input  logic [7:0] rdata,
    output logic       read,
    output logic       txd,
    output logic       busy,
    output logic       frame_done
);

    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(CLKS_PER_BIT - 1);

    typedef enum logic [2:0] {
        IDLE,
        FETCH,
        LOAD,
        START,
        DATA,
`ifdef FIFO_UART_TX_PARITY_EN
        PARITY,
`endif
        STOP
    } state_t;

    state_t           state_reg, state_next;
    logic             txd_reg, txd_next;
    logic [7:0]       shift_reg, shift_next;
    logic [CNT_W-1:0] cnt_reg, cnt_next;
    logic [2:0]       idx_reg, idx_next;
    logic             bit_end;
`ifdef FIFO_UART_TX_PARITY_EN
    logic             parity_reg, parity_next;
`endif

    always_ff @(posedge clk) begin
        if (reset) begin
            state_reg  <= IDLE;
            txd_reg    <= 1'b1;
            shift_reg  <= '0;
            cnt_reg    <= '0;
            idx_reg    <= '0;
`ifdef FIFO_UART_TX_PARITY_EN
            parity_reg <= 1'b0;
`endif
        end else begin
            state_reg  <= state_next;
            txd_reg    <= txd_next;
            shift_reg  <= shift_next;
            cnt_reg    <= cnt_next;
            idx_reg    <= idx_next;
`ifdef FIFO_UART_TX_PARITY_EN
            parity_reg <= parity_next;
`endif
        end
    end

    assign bit_end = (cnt_reg == '0);

    always_comb begin
        state_next  = state_reg;
        txd_next    = txd_reg;
        shift_next  = shift_reg;
        cnt_next    = cnt_reg;
        idx_next    = idx_reg;
`ifdef FIFO_UART_TX_PARITY_EN
        parity_next = parity_reg;
`endif

        // Every bit-timed state counts down and reloads at the bit boundary.
        if (state_reg != IDLE && state_reg != FETCH && state_reg != LOAD) begin
            cnt_next = bit_end ? CNT_MAX : cnt_reg - CNT_W'(1);
        end

        case (state_reg)
            IDLE: begin
                txd_next = 1'b1;
                if (enable && emptyB) begin
                    state_next = FETCH;
                end
            end
            FETCH: begin
                state_next = LOAD;
            end
            LOAD: begin
                // rdata is the registered output of the pop issued in FETCH.
                shift_next = rdata;
                txd_next   = 1'b0;
                cnt_next   = CNT_MAX;
`ifdef FIFO_UART_TX_PARITY_EN
                parity_next = ^rdata;
`endif
                state_next = START;
            end
            START: begin
                if (bit_end) begin
                    txd_next   = shift_reg[0];
                    idx_next   = '0;
                    state_next = DATA;
                end
            end
            DATA: begin
                if (bit_end) begin
                    if (idx_reg != 3'd7) begin
                        shift_next = {1'b0, shift_reg[7:1]};
                        txd_next   = shift_reg[1];
                        idx_next   = idx_reg + 3'd1;
                    end else begin
`ifdef FIFO_UART_TX_PARITY_EN
                        txd_next   = parity_reg;
                        state_next = PARITY;
`else
                        txd_next   = 1'b1;
                        state_next = STOP;
`endif
                    end
                end
            end
`ifdef FIFO_UART_TX_PARITY_EN
            PARITY: begin
                if (bit_end) begin
                    txd_next   = 1'b1;
                    state_next = STOP;
                end
            end
`endif
            STOP: begin
                if (bit_end) begin
                    cnt_next   = '0;
                    state_next = IDLE;
                end
            end
            default: begin
                txd_next   = 1'b1;
                state_next = IDLE;
            end
        endcase
    end

    assign read       = (state_reg == FETCH);
    assign busy       = (state_reg != IDLE);
    assign frame_done = (state_reg == STOP) && bit_end;
    assign txd        = txd_reg;

endmodule

// File: tb/tb_fifo_uart_tx.sv
// Self-checking bench for fifo_uart_tx with CLKS_PER_BIT=4 and a behavioural replay FIFO.
// Frame expectations follow FIFO_UART_TX_PARITY_EN when it is defined.
module tb_fifo_uart_tx;

    localparam int CPB = 4;
`ifdef FIFO_UART_TX_PARITY_EN
    localparam int NB  = 11;
    localparam bit PAR = 1'b1;
`else
    localparam int NB  = 10;
    localparam bit PAR = 1'b0;
`endif
    localparam int FL = NB * CPB;

    logic       clk    = 1'b0;
    logic       reset  = 1'b1;
    logic       enable = 1'b0;
    logic       emptyB = 1'b0;
    logic [7:0] rdata  = 8'h00;
    logic       read, txd, busy, frame_done;

    always #5 clk = ~clk;

    fifo_uart_tx #(.CLKS_PER_BIT(CPB), .CNT_W(16)) dut (
        .clk        (clk),
        .reset      (reset),
        .enable     (enable),
        .emptyB     (emptyB),
        .rdata      (rdata),
        .read       (read),
        .txd        (txd),
        .busy       (busy),
        .frame_done (frame_done)
    );

    typedef struct {
        logic [7:0] data;
        logic [9:0] frame;   // {stop, data[7:0], start}, hand-computed
        logic       par;     // even parity of data, hand-computed
    } vec_t;

    int errors = 0;
    int checks = 0;

    logic [7:0] mem [0:15];
    int   wr_ptr = 0;
    int   rd_ptr = 0;
    bit   pend   = 1'b0;
    int   reads  = 0;
    int   cyc_n  = 0;
    logic s_txd, s_read, s_busy, s_fd;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    // One clock: sample outputs mid-cycle, then advance the FIFO model.
    task automatic cyc();
        @(negedge clk);
        cyc_n++;
        s_txd  = txd;
        s_read = read;
        s_busy = busy;
        s_fd   = frame_done;
        if (pend) begin
            rdata  = mem[rd_ptr];
            rd_ptr = rd_ptr + 1;
            pend   = 1'b0;
        end
        if (s_read === 1'b1) begin
            pend  = 1'b1;
            reads = reads + 1;
        end
        emptyB = (rd_ptr != wr_ptr);
    endtask

    task automatic push(input logic [7:0] d);
        mem[wr_ptr] = d;
        wr_ptr      = wr_ptr + 1;
        emptyB      = (rd_ptr != wr_ptr);
    endtask

    function automatic logic [10:0] expf(input logic [9:0] f, input logic p);
        if (PAR) return {1'b1, p, f[8:0]};
        else     return {1'b0, f};
    endfunction

    task automatic wait_start(input string name);
        bit ok = 1'b0;
        for (int i = 0; i < 200; i++) begin
            cyc();
            if (s_txd === 1'b0) begin
                ok = 1'b1;
                break;
            end
        end
        check({name, "_start_seen"}, 32'(ok), 32'd1);
    endtask

    // Current sample must be the first start-bit cycle. act_kind: 1 drops enable, 2 pulses replay.
    task automatic frame_check(input string name, input logic [10:0] exp,
                               input int act_at, input int act_kind);
        logic [10:0] fr = '0;
        bit hold_ok = 1'b1;
        int fd_cnt = 0;
        int fd_pos = -1;
        int rd_cnt = 0;
        for (int i = 0; i < FL; i++) begin
            if (i > 0) cyc();
            if (i % CPB == 0) fr[i / CPB] = s_txd;
            else if (s_txd !== fr[i / CPB]) hold_ok = 1'b0;
            if (s_fd === 1'b1) begin
                fd_cnt++;
                fd_pos = i;
            end
            if (s_read === 1'b1) rd_cnt++;
            if (i == act_at && act_kind == 1) enable = 1'b0;
            if (i == act_at && act_kind == 2) begin
                rd_ptr = 0;
                emptyB = (rd_ptr != wr_ptr);
            end
        end
        $display("frame %s: txd bits %b, expected %b", name, fr, exp);
        check({name, "_bits"}, 32'(fr), 32'(exp));
        check({name, "_bit_hold"}, 32'(hold_ok), 32'd1);
        check({name, "_done_count"}, 32'(fd_cnt), 32'd1);
        check({name, "_done_pos"}, 32'(fd_pos), 32'(FL - 1));
        check({name, "_no_read_in_frame"}, 32'(rd_cnt), 32'd0);
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        vec_t vecs [6];
        int r0;
        int last_start;
        logic [7:0]  t2_data [3];
        logic [10:0] t2_exp  [3];
        logic [10:0] t5_exp  [6];

        vecs[0] = '{8'h55, 10'h2AA, 1'b0};
        vecs[1] = '{8'h00, 10'h200, 1'b0};
        vecs[2] = '{8'h80, 10'h300, 1'b1};
        vecs[3] = '{8'h01, 10'h202, 1'b1};
        vecs[4] = '{8'h07, 10'h20E, 1'b1};
        vecs[5] = '{8'h03, 10'h206, 1'b0};

        // Reset state
        repeat (3) cyc();
        check("reset_txd", 32'(s_txd), 32'd1);
        check("reset_read", 32'(s_read), 32'd0);
        check("reset_busy", 32'(s_busy), 32'd0);
        check("reset_frame_done", 32'(s_fd), 32'd0);
        reset = 1'b0;
        cyc();

        // Single frames from the table: read pulse, two-cycle latency, frame shape
        enable = 1'b1;
        for (int v = 0; v < 6; v++) begin
            bit seen = 1'b0;
            push(vecs[v].data);
            for (int i = 0; i < 20; i++) begin
                cyc();
                if (s_read === 1'b1) begin
                    seen = 1'b1;
                    break;
                end
            end
            check("vec_read_seen", 32'(seen), 32'd1);
            cyc();
            check("vec_load_read_low", 32'(s_read), 32'd0);
            check("vec_load_txd_high", 32'(s_txd), 32'd1);
            cyc();
            check("vec_txd_falls", 32'(s_txd), 32'd0);
            frame_check($sformatf("vec%0d", v), expf(vecs[v].frame, vecs[v].par), -1, 0);
            cyc();
            check("vec_busy_after", 32'(s_busy), 32'd0);
            check("vec_txd_idle", 32'(s_txd), 32'd1);
        end

        // Back-to-back frames with three-cycle inter-frame gap
        enable = 1'b0;
        cyc();
        t2_data = '{8'h41, 8'h42, 8'h43};
        t2_exp  = '{expf(10'h282, 1'b0), expf(10'h284, 1'b0), expf(10'h286, 1'b1)};
        for (int k = 0; k < 3; k++) push(t2_data[k]);
        r0 = reads;
        enable = 1'b1;
        last_start = 0;
        for (int k = 0; k < 3; k++) begin
            wait_start($sformatf("b2b%0d", k));
            if (k > 0) check("b2b_gap", 32'(cyc_n - last_start), 32'(FL + 3));
            last_start = cyc_n;
            frame_check($sformatf("b2b%0d", k), t2_exp[k], -1, 0);
        end
        repeat (10) cyc();
        check("b2b_read_count", 32'(reads - r0), 32'd3);
        check("b2b_idle", 32'(s_busy), 32'd0);

        // enable dropped during data bit 3: frame completes, nothing new starts
        enable = 1'b0;
        push(8'hA5);
        push(8'h3C);
        r0 = reads;
        enable = 1'b1;
        wait_start("en_drop");
        frame_check("en_drop", expf(10'h34A, 1'b0), 4 * CPB + 1, 1);
        repeat (20) cyc();
        check("en_drop_reads", 32'(reads - r0), 32'd1);
        check("en_drop_idle", 32'(s_busy), 32'd0);
        enable = 1'b1;
        wait_start("en_resume");
        frame_check("en_resume", expf(10'h278, 1'b0), -1, 0);
        check("en_resume_reads", 32'(reads - r0), 32'd2);

        // Reset during data bit 5 of 0xFF
        push(8'hFF);
        wait_start("rst_mid");
        repeat (6 * CPB + 1) cyc();
        reset = 1'b1;
        cyc();
        check("rst_mid_txd", 32'(s_txd), 32'd1);
        check("rst_mid_busy", 32'(s_busy), 32'd0);
        check("rst_mid_done", 32'(s_fd), 32'd0);
        reset = 1'b0;
        r0 = reads;
        repeat (5) cyc();
        check("rst_release_no_read", 32'(reads - r0), 32'd0);

        // Replay pulsed mid-frame after two bytes: stored bytes are resent in order
        enable = 1'b0;
        cyc();
        wr_ptr = 0;
        rd_ptr = 0;
        emptyB = 1'b0;
        push(8'h11);
        push(8'h22);
        push(8'h33);
        t5_exp = '{expf(10'h222, 1'b0), expf(10'h244, 1'b0), expf(10'h266, 1'b0),
                   expf(10'h222, 1'b0), expf(10'h244, 1'b0), expf(10'h266, 1'b0)};
        r0 = reads;
        enable = 1'b1;
        for (int k = 0; k < 6; k++) begin
            wait_start($sformatf("replay%0d", k));
            frame_check($sformatf("replay%0d", k), t5_exp[k], (k == 2) ? 5 * CPB : -1, 2);
        end
        repeat (10) cyc();
        check("replay_read_count", 32'(reads - r0), 32'd6);
        check("replay_idle", 32'(s_busy), 32'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
